// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU scratch-area blocks.
//   - state_t : control states of the bit-serial arithmetic units
//               (IDLE, SHIFT, DONE), encoded in two bits.
//   - ALU_MIN_WIDTH / ALU_MAX_WIDTH : supported operand width range.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_MIN_WIDTH = 2;
    localparam int ALU_MAX_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor cell: computes a - b - bin.
//   Ports:
//     a    in  1  minuend bit
//     b    in  1  subtrahend bit
//     bin  in  1  borrow in from the less significant bit
//     d    out 1  difference bit
//     bout out 1  borrow out to the more significant bit
//   Purely combinational.
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when a == b and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial A - B subtractor. Operands are taken over a valid/ready
//   handshake, processed LSB-first one bit per clock through a single
//   full_subtractor cell and a borrow flop, and the result plus flags are
//   offered over a valid/ready output handshake.
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous active-high reset
//     in_valid   in   1      operands present
//     in_ready   out  1      ready for operands (IDLE only)
//     a          in   WIDTH  minuend
//     b          in   WIDTH  subtrahend
//     out_valid  out  1      result present (DONE only)
//     out_ready  in   1      consumer takes the result
//     diff       out  WIDTH  A - B modulo 2^WIDTH
//     borrow     out  1      unsigned borrow (A < B)
//     zero       out  1      diff == 0
//     ovf        out  1      signed overflow
// ---------------------------------------------------------------------------
module serial_subtractor
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic             br_q, br_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_a_q, sign_a_d;
    logic             sign_b_q, sign_b_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic             d_bit;
    logic             bout_bit;

    full_subtractor u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (bout_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sa_d     = a;
                    sb_d     = b;
                    br_d     = 1'b0;
                    cnt_d    = '0;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
                sd_d = {d_bit, sd_q[WIDTH-1:1]};
                br_d = bout_bit;
                if (cnt_q == CNT_LAST) begin
                    // The bit produced now is the MSB, so the flags can be
                    // settled from the completed word and the latched signs.
                    zero_d  = (sd_d == '0);
                    ovf_d   = (sign_a_q ^ sign_b_q) & (d_bit ^ sign_a_q);
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = sd_q;
    assign borrow    = br_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH = 8: a table of
//   hand-computed vectors, then backpressure, mid-operation reset and a long
//   back-to-back random run against a reference model.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         ovf;

    int checks;
    int errors;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } res_t;

    vec_t vecs[8];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero),
        .ovf       (ovf)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent arithmetic reference: wide subtraction gives the borrow,
    // sign rule gives signed overflow.
    function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        res_t       r;
        logic [W:0] wide;
        wide     = {1'b0, x} - {1'b0, y};
        r.diff   = wide[W-1:0];
        r.borrow = wide[W];
        r.zero   = (wide[W-1:0] == '0);
        r.ovf    = (x[W-1] != y[W-1]) && (wide[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Presents one operand pair from IDLE (called #1 after an edge) and waits,
    // bounded, for the result, checking the accept-to-valid latency.
    task automatic apply_stimulus(input logic [W-1:0] ai, input logic [W-1:0] bi);
        int lat;
        a        = ai;
        b        = bi;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_output("latency", lat, W);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("release_out_valid", out_valid, 0);
        check_output("release_in_ready", in_ready, 1);
    endtask

    initial begin
        int         stall_bad;
        logic [W-1:0] held_diff;
        logic       held_borrow, held_zero, held_ovf;
        logic [W-1:0] qa[$];
        logic [W-1:0] qb[$];
        logic [W-1:0] ta, tb;
        res_t       exp_r;
        int         got_ops;
        int         last_cycle;
        int         cyc;

        checks = 0;
        errors = 0;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        #3;
        check_output("rst_in_ready", in_ready, 1);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_diff", diff, 0);
        check_output("rst_borrow", borrow, 0);
        check_output("rst_zero", zero, 0);
        check_output("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b);
            check_output($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
            check_output($sformatf("vec%0d_borrow", i), borrow, vecs[i].borrow);
            check_output($sformatf("vec%0d_zero", i), zero, vecs[i].zero);
            check_output($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
            check_output($sformatf("vec%0d_in_ready", i), in_ready, 0);
            release_result();
        end

        // Backpressure: result held 20 cycles while new operands are offered
        apply_stimulus(8'h33, 8'h11);
        held_diff   = diff;
        held_borrow = borrow;
        held_zero   = zero;
        held_ovf    = ovf;
        check_output("bp_diff", held_diff, 8'h22);
        stall_bad = 0;
        in_valid  = 1'b1;
        a         = 8'hAA;
        b         = 8'h01;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== held_diff ||
                borrow !== held_borrow || zero !== held_zero || ovf !== held_ovf)
                stall_bad++;
        end
        check_output("bp_stable_cycles_bad", stall_bad, 0);
        in_valid = 1'b0;
        release_result();
        check_output("bp_diff_after", diff, 8'h22);

        // Asynchronous reset in the middle of SHIFT (count == 3)
        a        = 8'h44;
        b        = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("midrst_in_ready", in_ready, 1);
        check_output("midrst_out_valid", out_valid, 0);
        check_output("midrst_diff", diff, 0);
        #1;
        rst = 1'b0;
        stall_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) stall_bad++;
        end
        check_output("midrst_no_stale", stall_bad, 0);
        apply_stimulus(8'h09, 8'h04);
        check_output("after_rst_diff", diff, 8'h05);
        check_output("after_rst_borrow", borrow, 0);
        release_result();

        // Back-to-back random run with both handshakes tied high
        got_ops    = 0;
        last_cycle = -1;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        for (cyc = 0; cyc < 20000 && got_ops < 1000; cyc++) begin
            if (out_valid) begin
                if (qa.size() == 0) begin
                    check_output("b2b_unexpected_result", 1, 0);
                end else begin
                    ta    = qa.pop_front();
                    tb    = qb.pop_front();
                    exp_r = ref_sub(ta, tb);
                    check_output("b2b_diff", diff, exp_r.diff);
                    check_output("b2b_borrow", borrow, exp_r.borrow);
                    check_output("b2b_zero", zero, exp_r.zero);
                    check_output("b2b_ovf", ovf, exp_r.ovf);
                end
                if (last_cycle >= 0)
                    check_output("b2b_period", cyc - last_cycle, W + 2);
                last_cycle = cyc;
                got_ops++;
            end
            if (in_ready && qa.size() < 1000 + 1) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                qa.push_back(a);
                qb.push_back(b);
            end
            @(posedge clk);
            #1;
        end
        check_output("b2b_ops_done", got_ops, 1000);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
